alu_logic_sliced: RTL

//  Parametrised successor to the 8-bit ALU RHS bitwise-logic stage. Computes any 2-input bitwise

---
 rtl/alu_logic_sliced.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_logic_sliced.sv
// alu_logic_sliced: any 2-input bitwise function of LHS/RHS, chosen by a 4-bit truth table,
// evaluated SLICE bits per clock under a Start/Ready/Valid handshake.
module alu_logic_sliced #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             AluClock,
  input  logic             Reset,
  input  logic             Start,
  output logic             Ready,
  input  logic [3:0]       Func,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  output logic [WIDTH-1:0] Logic,
  output logic             Zero,
  output logic             Valid
);

  localparam int NSLICES = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam bit BAD_CFG = (SLICE < 1) ? 1'b1 : ((WIDTH % SLICE) != 0);
  localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

  generate
    if (BAD_CFG || (NSLICES < 1)) begin : g_bad_cfg
      $error("alu_logic_sliced: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  // Bit i of the result is entry {a[i],b[i]} of the truth table.
  function automatic logic [SLICE-1:0] apply_table(
    input logic [3:0]       tt,
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b
  );
    logic [SLICE-1:0] r;
    r = {SLICE{1'b0}};
    for (int i = 0; i < SLICE; i++) begin
      r[i] = tt[{a[i], b[i]}];
    end
    return r;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       func_r;
  logic [WIDTH-1:0] lhs_r;
  logic [WIDTH-1:0] rhs_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] logic_r;
  logic             zero_r;
  logic             valid_r;

  logic             accept_s;
  logic             last_s;
  logic [SLICE-1:0] lhs_slice_s;
  logic [SLICE-1:0] rhs_slice_s;
  logic [WIDTH-1:0] acc_next_s;

  // Next-state decode: accept in IDLE, finish on the last slice in BUSY.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_next_s = BUSY;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST) begin
          state_next_s = IDLE;
          last_s       = 1'b1;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Current slice of the latched operands merged into the accumulator.
  always_comb begin
    lhs_slice_s = lhs_r[int'(cnt_r) * SLICE +: SLICE];
    rhs_slice_s = rhs_r[int'(cnt_r) * SLICE +: SLICE];
    acc_next_s  = acc_r;
    acc_next_s[int'(cnt_r) * SLICE +: SLICE] = apply_table(func_r, lhs_slice_s, rhs_slice_s);
  end

  // State register.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Slice counter, operand latches and accumulator.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      cnt_r  <= {CW{1'b0}};
      func_r <= 4'b0000;
      lhs_r  <= {WIDTH{1'b0}};
      rhs_r  <= {WIDTH{1'b0}};
      acc_r  <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r  <= {CW{1'b0}};
      func_r <= Func;
      lhs_r  <= LHS;
      rhs_r  <= RHS;
      acc_r  <= {WIDTH{1'b0}};
    end else if (state_r == BUSY) begin
      cnt_r  <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
      acc_r  <= acc_next_s;
    end
  end

  // Result, Zero and the one-cycle Valid pulse change only on completion or reset.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      logic_r <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (last_s) begin
      logic_r <= acc_next_s;
      zero_r  <= (acc_next_s == {WIDTH{1'b0}});
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign Ready = (state_r == IDLE);
  assign Logic = logic_r;
  assign Zero  = zero_r;
  assign Valid = valid_r;

endmodule
